// File: rtl/req_gnt_pkg.sv
// Shared constants and types for the 3-channel req/gnt grant scheduler.
package req_gnt_pkg;

    // Channel indices into req/gnt
    localparam int unsigned CH_FAST = 0;
    localparam int unsigned CH_WIN  = 1;
    localparam int unsigned CH_ZERO = 2;
    localparam int unsigned N_REQ   = 3;

    // Default ch1 latency window and counter width
    localparam int unsigned DEF_WIN_MIN_LAT = 3;
    localparam int unsigned DEF_WIN_MAX_LAT = 5;
    localparam int unsigned DEF_LAT_W       = 3;

    typedef enum logic {
        WIN_IDLE = 1'b0,
        WIN_WAIT = 1'b1
    } win_state_t;

endpackage

// File: rtl/req_gnt_if.sv
// 3-channel req/gnt bundle between requesters (master) and the scheduler (slave).
//  req          requests, bit i = channel i
//  gnt          one-cycle grant pulses, at most one bit high
//  ch2_ready    combinational; req[2] may be raised only while high
//  ch1_pending  ch1 request captured, grant not yet issued
//  ch1_overrun  sticky ch1 latency-window miss
interface req_gnt_if;

    logic [req_gnt_pkg::N_REQ-1:0] req;
    logic [req_gnt_pkg::N_REQ-1:0] gnt;
    logic                          ch2_ready;
    logic                          ch1_pending;
    logic                          ch1_overrun;

    modport master (
        output req,
        input  gnt,
        input  ch2_ready,
        input  ch1_pending,
        input  ch1_overrun
    );

    modport slave (
        input  req,
        output gnt,
        output ch2_ready,
        output ch1_pending,
        output ch1_overrun
    );

endinterface

// File: rtl/req_gnt_win_timer.sv
// ch1 "window" channel: captures a request, then grants inside [WIN_MIN_LAT, WIN_MAX_LAT].
//  clk, reset_n  clock, async active-low reset
//  req1_i        ch1 request
//  block_i       ch0 grant is being registered this edge; ch1 must defer
//  gnt1_o        registered one-cycle ch1 grant
//  pending_o     registered; request captured and grant not yet past
//  overrun_o     registered sticky; window missed
module req_gnt_win_timer
    import req_gnt_pkg::*;
#(
    parameter int unsigned WIN_MIN_LAT = DEF_WIN_MIN_LAT,
    parameter int unsigned WIN_MAX_LAT = DEF_WIN_MAX_LAT,
    parameter int unsigned LAT_W       = DEF_LAT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req1_i,
    input  logic block_i,
    output logic gnt1_o,
    output logic pending_o,
    output logic overrun_o
);

    // Parameter legality
    if (WIN_MIN_LAT < 1) begin : g_err_min
        $error("WIN_MIN_LAT must be >= 1");
    end
    if (WIN_MAX_LAT < WIN_MIN_LAT + 1) begin : g_err_max
        $error("WIN_MAX_LAT must be >= WIN_MIN_LAT+1");
    end
    if (WIN_MAX_LAT >= (2 ** LAT_W)) begin : g_err_w
        $error("LAT_W too narrow to hold WIN_MAX_LAT");
    end

    localparam logic [LAT_W-1:0] MIN_C = LAT_W'(WIN_MIN_LAT);
    localparam logic [LAT_W-1:0] MAX_C = LAT_W'(WIN_MAX_LAT);

    win_state_t       state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             gnt1_q, gnt1_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= WIN_IDLE;
            cnt_q     <= '0;
            gnt1_q    <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt1_q    <= gnt1_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Next state; the decision uses the post-increment count so a request sampled
    // at edge T is visible as a grant at sample T+cnt.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt1_d    = 1'b0;
        overrun_d = overrun_q;
        cnt_inc   = (cnt_q >= MAX_C) ? MAX_C : cnt_q + LAT_W'(1);

        case (state_q)
            WIN_IDLE: begin
                if (req1_i) begin
                    state_d = WIN_WAIT;
                    cnt_d   = LAT_W'(1);
                end
            end
            WIN_WAIT: begin
                cnt_d = cnt_inc;
                if (cnt_inc >= MIN_C) begin
                    if (!block_i) begin
                        gnt1_d  = 1'b1;
                        state_d = WIN_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc >= MAX_C) begin
                        // Window exhausted: flag it and grant regardless
                        overrun_d = 1'b1;
                        gnt1_d    = 1'b1;
                        state_d   = WIN_IDLE;
                        cnt_d     = '0;
                    end
                end
            end
            default: begin
                state_d = WIN_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pending stays up through the cycle the grant is visible
        pending_d = (state_d == WIN_WAIT) | gnt1_d;
    end

    assign gnt1_o    = gnt1_q;
    assign pending_o = pending_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/req_gnt_scheduler.sv
// Grant scheduler for the 3-channel req/gnt interface; sole driver of gnt.
//  clk      rising-edge clock
//  reset_n  asynchronous active-low reset
//  bus      req_gnt_if slave: req in; gnt, ch2_ready, ch1_pending, ch1_overrun out
//  ch0 fast (registered, 1 cycle after rise), ch1 window (sub-module),
//  ch2 zero-latency (combinational, masked by any registered grant).
module req_gnt_scheduler
    import req_gnt_pkg::*;
#(
    parameter int unsigned WIN_MIN_LAT = DEF_WIN_MIN_LAT,
    parameter int unsigned WIN_MAX_LAT = DEF_WIN_MAX_LAT,
    parameter int unsigned LAT_W       = DEF_LAT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    req_gnt_if.slave     bus
);

    logic             req0_q;
    logic             gnt0_q;
    logic             rose0_c;
    logic             gnt1_q;
    logic             ch2_ready_c;
    logic             gnt2_c;
    logic [N_REQ-1:0] gnt_c;

    // ch0 rise detector; req0_q resets low so a req held at release counts as a rise
    assign rose0_c = bus.req[CH_FAST] & ~req0_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req0_q <= 1'b0;
            gnt0_q <= 1'b0;
        end else begin
            req0_q <= bus.req[CH_FAST];
            gnt0_q <= rose0_c;
        end
    end

    // ch1 defers to ch0 on the edge ch0 is registered, keeping them exclusive
    req_gnt_win_timer #(
        .WIN_MIN_LAT (WIN_MIN_LAT),
        .WIN_MAX_LAT (WIN_MAX_LAT),
        .LAT_W       (LAT_W)
    ) u_win_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .req1_i    (bus.req[CH_WIN]),
        .block_i   (rose0_c),
        .gnt1_o    (gnt1_q),
        .pending_o (bus.ch1_pending),
        .overrun_o (bus.ch1_overrun)
    );

    // ch2 only while no registered grant is out
    assign ch2_ready_c = ~gnt0_q & ~gnt1_q;
    assign gnt2_c      = bus.req[CH_ZERO] & ch2_ready_c;

    always_comb begin
        gnt_c          = '0;
        gnt_c[CH_FAST] = gnt0_q;
        gnt_c[CH_WIN]  = gnt1_q;
        gnt_c[CH_ZERO] = gnt2_c;
    end

    assign bus.gnt       = gnt_c;
    assign bus.ch2_ready = ch2_ready_c;

endmodule

// File: tb/tb_req_gnt_scheduler.sv
// Self-checking bench for req_gnt_scheduler: expected ch0/ch1 grant events are
// queued as stimulus is driven and matched against gnt at every sample.
module tb_req_gnt_scheduler;
    import req_gnt_pkg::*;

    typedef struct {
        int unsigned ch;
        int          edge_no;
    } exp_t;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sb[$];

    req_gnt_if bus ();

    req_gnt_scheduler #(
        .WIN_MIN_LAT (3),
        .WIN_MAX_LAT (5),
        .LAT_W       (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Advance to the next negedge, match outputs against the scoreboard, then drive req.
    // e is the number of the edge at which the observed outputs and the new req are sampled.
    task automatic step(input logic [2:0] r, output int e);
        logic [1:0] g;
        logic [1:0] eg;
        exp_t       x;
        @(negedge clk);
        e = cyc + 1;
        checks++;
        if ($countones(bus.gnt) > 1) begin
            errors++;
            $display("FAIL popcount edge %0d gnt=%b required at most one bit", e, bus.gnt);
        end
        g = bus.gnt[1:0];
        if (g != 2'b00) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant edge %0d gnt=%b required 00", e, g);
            end else begin
                x  = sb.pop_front();
                eg = 2'b01 << x.ch;
                if (g !== eg || e != x.edge_no) begin
                    errors++;
                    $display("FAIL grant_match edge %0d gnt=%b required %b at edge %0d",
                             e, g, eg, x.edge_no);
                end
            end
        end else if (sb.size() > 0 && sb[0].edge_no <= e) begin
            checks++;
            errors++;
            x = sb.pop_front();
            $display("FAIL missing_grant edge %0d gnt=00 required ch%0d at edge %0d",
                     e, x.ch, x.edge_no);
        end
        bus.req = r;
    endtask

    task automatic test_reset();
        int e;
        reset_n = 1'b0;
        bus.req = 3'b000;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.gnt !== 3'b000) begin
            errors++; $display("FAIL reset_gnt got=%b required=000", bus.gnt);
        end
        checks++;
        if (bus.ch1_pending !== 1'b0 || bus.ch1_overrun !== 1'b0) begin
            errors++; $display("FAIL reset_flags pending=%b overrun=%b required 0 0",
                               bus.ch1_pending, bus.ch1_overrun);
        end
        checks++;
        if (bus.ch2_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b required=1", bus.ch2_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step(3'b000, e);
        step(3'b000, e);
    endtask

    task automatic test_fast();
        int e0, e;
        step(3'b001, e0);
        sb.push_back('{CH_FAST, e0 + 1});
        step(3'b000, e);
        checks++;
        if (bus.gnt !== 3'b001) begin
            errors++; $display("FAIL fast_pulse edge %0d gnt=%b required=001", e, bus.gnt);
        end
        step(3'b000, e);
        checks++;
        if (bus.gnt !== 3'b000) begin
            errors++; $display("FAIL fast_single edge %0d gnt=%b required=000", e, bus.gnt);
        end
    endtask

    task automatic test_window();
        int   e0, e;
        logic exp_p;
        step(3'b010, e0);
        sb.push_back('{CH_WIN, e0 + 3});
        for (int i = 1; i <= 5; i++) begin
            step(3'b000, e);
            exp_p = (i <= 3);
            checks++;
            if (bus.ch1_pending !== exp_p) begin
                errors++; $display("FAIL win_pending edge %0d got=%b required=%b",
                                   e, bus.ch1_pending, exp_p);
            end
        end
    endtask

    task automatic test_defer();
        int   e0, e;
        logic exp_p;
        step(3'b010, e0);
        step(3'b000, e);
        step(3'b001, e);
        sb.push_back('{CH_FAST, e0 + 3});
        sb.push_back('{CH_WIN,  e0 + 4});
        for (int i = 3; i <= 6; i++) begin
            step(3'b000, e);
            exp_p = (i <= 4);
            checks++;
            if (bus.ch1_pending !== exp_p) begin
                errors++; $display("FAIL defer_pending edge %0d got=%b required=%b",
                                   e, bus.ch1_pending, exp_p);
            end
        end
        checks++;
        if (bus.ch1_overrun !== 1'b0) begin
            errors++; $display("FAIL defer_overrun edge %0d got=%b required=0", e, bus.ch1_overrun);
        end
    endtask

    task automatic test_ch2();
        int e0, e;
        step(3'b100, e);
        #1;
        checks++;
        if (bus.ch2_ready !== 1'b1 || bus.gnt !== 3'b100) begin
            errors++; $display("FAIL ch2_grant edge %0d ready=%b gnt=%b required 1 100",
                               e, bus.ch2_ready, bus.gnt);
        end
        step(3'b000, e);
        step(3'b001, e0);
        sb.push_back('{CH_FAST, e0 + 1});
        step(3'b100, e);
        #1;
        checks++;
        if (bus.ch2_ready !== 1'b0 || bus.gnt !== 3'b001) begin
            errors++; $display("FAIL ch2_masked edge %0d ready=%b gnt=%b required 0 001",
                               e, bus.ch2_ready, bus.gnt);
        end
        step(3'b000, e);
        #1;
        checks++;
        if (bus.ch2_ready !== 1'b1 || bus.gnt !== 3'b000) begin
            errors++; $display("FAIL ch2_idle edge %0d ready=%b gnt=%b required 1 000",
                               e, bus.ch2_ready, bus.gnt);
        end
    endtask

    task automatic test_back_to_back();
        int         e0, e;
        logic       exp_p;
        logic [2:0] r;
        step(3'b001, e0);
        sb.push_back('{CH_FAST, e0 + 1});
        repeat (5) step(3'b001, e);
        step(3'b000, e);
        step(3'b000, e);
        checks++;
        if (bus.gnt !== 3'b000) begin
            errors++; $display("FAIL held_req0 edge %0d gnt=%b required=000", e, bus.gnt);
        end
        step(3'b010, e0);
        for (int k = 1; k <= 4; k++) sb.push_back('{CH_WIN, e0 + 3 * k});
        for (int i = 1; i <= 13; i++) begin
            r = (i <= 9) ? 3'b010 : 3'b000;
            step(r, e);
            exp_p = (i <= 12);
            checks++;
            if (bus.ch1_pending !== exp_p) begin
                errors++; $display("FAIL b2b_pending edge %0d got=%b required=%b",
                                   e, bus.ch1_pending, exp_p);
            end
        end
        checks++;
        if (bus.ch1_overrun !== 1'b0) begin
            errors++; $display("FAIL b2b_overrun edge %0d got=%b required=0", e, bus.ch1_overrun);
        end
    endtask

    task automatic test_reset_mid();
        int e0, e;
        step(3'b010, e0);
        step(3'b000, e);
        step(3'b000, e);
        checks++;
        if (bus.ch1_pending !== 1'b1) begin
            errors++; $display("FAIL mid_wait_pending edge %0d got=%b required=1", e, bus.ch1_pending);
        end
        reset_n = 1'b0;
        bus.req = 3'b001;
        #1;
        checks++;
        if (bus.gnt !== 3'b000 || bus.ch1_pending !== 1'b0 || bus.ch1_overrun !== 1'b0) begin
            errors++; $display("FAIL async_reset gnt=%b pending=%b overrun=%b required 000 0 0",
                               bus.gnt, bus.ch1_pending, bus.ch1_overrun);
        end
        @(negedge clk);
        step(3'b001, e);
        reset_n = 1'b1;
        sb.push_back('{CH_FAST, e + 1});
        step(3'b000, e);
        checks++;
        if (bus.gnt !== 3'b001) begin
            errors++; $display("FAIL release_grant edge %0d gnt=%b required=001", e, bus.gnt);
        end
        repeat (6) step(3'b000, e);
    endtask

    initial begin
        bus.req = 3'b000;
        reset_n = 1'b0;
        test_reset();
        test_fast();
        test_window();
        test_defer();
        test_ch2();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
